// File: rtl/cpu_mem_loader_pkg.sv
// Shared opcodes and FSM encoding for the cpu memory loader.
// No timing or flow control of its own; consumed by cpu_mem_loader and its bench.
package loader_pkg;

    localparam logic [2:0] OP_WR_IMEM = 3'b000;
    localparam logic [2:0] OP_WR_DMEM = 3'b001;
    localparam logic [2:0] OP_RD_IMEM = 3'b010;
    localparam logic [2:0] OP_RD_DMEM = 3'b011;
    localparam logic [2:0] OP_RUN     = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_RSP,
        ST_RUN,
        ST_DONE
    } state_t;

    // Bit 0 of every memory opcode selects DMEM over IMEM.
    function automatic logic op_is_dmem(input logic [2:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/cpu_mem_loader_if.sv
// Host command/response link: valid/ready command in, valid/ready read data out.
// Pure wiring; the loader is the slave, the host side is the master.
interface cpu_mem_loader_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/cpu_mem_loader_run_counter.sv
// Loadable down-counter holding the remaining RUN cycles; saturates at zero.
// Load/decrement take effect on the next edge; zero and last flags are registered-state decodes.
module run_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
    assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/cpu_mem_loader.sv
// Host-side initiator for the cpu IMEM/DMEM external ports and cpu enable; one command at a time.
// Outputs registered (write 2 cycles/cmd, read 1+READ_LAT cycles to rsp); cmd_ready low until IDLE, rsp held until rsp_ready.
module cpu_mem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int CNT_W    = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              arst_n,
    cpu_mem_loader_if.slave   host,
    output logic              run_done,
    output logic              busy,
    output logic              cpu_enable,
    output logic [ADDR_W-1:0] addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [DATA_W-1:0] wdata_ext,
    input  logic [DATA_W-1:0] rdata_ext,
    output logic [ADDR_W-1:0] addr_ext_2,
    output logic              wen_ext_2,
    output logic              ren_ext_2,
    output logic [DATA_W-1:0] wdata_ext_2,
    input  logic [DATA_W-1:0] rdata_ext_2
);

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [7:0]        wait_q, wait_d;

    logic              wen_q, wen_d, ren_q, ren_d;
    logic              wen2_q, wen2_d, ren2_q, ren2_d;
    logic [ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
    logic [DATA_W-1:0] wdata1_q, wdata1_d, wdata2_q, wdata2_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              run_done_q, run_done_d;
    logic              busy_q, busy_d;
    logic              cpu_enable_q, cpu_enable_d;

    logic              accept;
    logic              cnt_load;
    logic              cnt_zero, cnt_last;
    logic              sel_dmem, acc_wr, acc_rd;

    run_counter #(.CNT_W(CNT_W)) u_run_counter (
        .clk        (clk),
        .arst_n     (arst_n),
        .load_i     (cnt_load),
        .load_val_i (host.cmd_data[CNT_W-1:0]),
        .dec_i      (state_q == ST_RUN),
        .zero_o     (cnt_zero),
        .last_o     (cnt_last)
    );

    // Gated with arst_n so every output reads 0 while reset is held.
    assign host.cmd_ready = arst_n && (state_q == ST_IDLE);
    assign accept         = host.cmd_valid && host.cmd_ready;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        data_d   = data_q;
        wait_d   = wait_q;
        cnt_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d   = host.cmd_op;
                    addr_d = host.cmd_addr;
                    data_d = host.cmd_data;
                    case (host.cmd_op)
                        OP_WR_IMEM, OP_WR_DMEM: state_d = ST_WRITE;
                        OP_RD_IMEM, OP_RD_DMEM: state_d = ST_RD_REQ;
                        OP_RUN: begin
                            cnt_load = 1'b1;
                            state_d  = (host.cmd_data[CNT_W-1:0] == '0) ? ST_DONE : ST_RUN;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_RD_REQ: begin
                if (READ_LAT <= 1) begin
                    state_d = ST_RSP;
                end else begin
                    state_d = ST_RD_WAIT;
                    wait_d  = 8'(READ_LAT - 2);
                end
            end
            ST_RD_WAIT: begin
                if (wait_q == 8'd0) begin
                    state_d = ST_RSP;
                end else begin
                    wait_d = wait_q - 8'd1;
                end
            end
            ST_RSP:  if (host.rsp_ready) state_d = ST_IDLE;
            ST_RUN:  if (cnt_last || cnt_zero) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output registers are decoded from the next state so they line up with state_q.
    always_comb begin
        sel_dmem     = op_is_dmem(op_d);
        acc_wr       = (state_d == ST_WRITE);
        acc_rd       = (state_d == ST_RD_REQ);
        wen_d        = acc_wr && !sel_dmem;
        wen2_d       = acc_wr && sel_dmem;
        ren_d        = acc_rd && !sel_dmem;
        ren2_d       = acc_rd && sel_dmem;
        addr1_d      = ((acc_wr || acc_rd) && !sel_dmem) ? addr_d : '0;
        addr2_d      = ((acc_wr || acc_rd) && sel_dmem) ? addr_d : '0;
        wdata1_d     = wen_d  ? data_d : '0;
        wdata2_d     = wen2_d ? data_d : '0;
        rsp_valid_d  = (state_d == ST_RSP);
        run_done_d   = (state_d == ST_DONE);
        busy_d       = (state_d != ST_IDLE);
        cpu_enable_d = (state_d == ST_RUN);
        rsp_data_d   = rsp_data_q;
        if ((state_d == ST_RSP) && (state_q != ST_RSP)) begin
            rsp_data_d = op_is_dmem(op_q) ? rdata_ext_2 : rdata_ext;
        end else if (state_d != ST_RSP) begin
            rsp_data_d = '0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            wait_q       <= '0;
            wen_q        <= 1'b0;
            ren_q        <= 1'b0;
            wen2_q       <= 1'b0;
            ren2_q       <= 1'b0;
            addr1_q      <= '0;
            addr2_q      <= '0;
            wdata1_q     <= '0;
            wdata2_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            run_done_q   <= 1'b0;
            busy_q       <= 1'b0;
            cpu_enable_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            wait_q       <= wait_d;
            wen_q        <= wen_d;
            ren_q        <= ren_d;
            wen2_q       <= wen2_d;
            ren2_q       <= ren2_d;
            addr1_q      <= addr1_d;
            addr2_q      <= addr2_d;
            wdata1_q     <= wdata1_d;
            wdata2_q     <= wdata2_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            run_done_q   <= run_done_d;
            busy_q       <= busy_d;
            cpu_enable_q <= cpu_enable_d;
        end
    end

    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_data  = rsp_data_q;
    assign run_done       = run_done_q;
    assign busy           = busy_q;
    assign cpu_enable     = cpu_enable_q;
    assign addr_ext       = addr1_q;
    assign wen_ext        = wen_q;
    assign ren_ext        = ren_q;
    assign wdata_ext      = wdata1_q;
    assign addr_ext_2     = addr2_q;
    assign wen_ext_2      = wen2_q;
    assign ren_ext_2      = ren2_q;
    assign wdata_ext_2    = wdata2_q;

endmodule

// File: tb/tb_cpu_mem_loader.sv
// Randomized bench for cpu_mem_loader: a scoreboard of expected port accesses, read data and run lengths.
module tb_cpu_mem_loader;
    import loader_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_mem_loader_if #(.ADDR_W(AW), .DATA_W(DW)) host ();

    logic          run_done, busy, cpu_enable;
    logic [AW-1:0] addr_ext, addr_ext_2;
    logic          wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic [DW-1:0] wdata_ext, wdata_ext_2, rdata_ext, rdata_ext_2;

    cpu_mem_loader #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .READ_LAT(1)) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .host        (host),
        .run_done    (run_done),
        .busy        (busy),
        .cpu_enable  (cpu_enable),
        .addr_ext    (addr_ext),
        .wen_ext     (wen_ext),
        .ren_ext     (ren_ext),
        .wdata_ext   (wdata_ext),
        .rdata_ext   (rdata_ext),
        .addr_ext_2  (addr_ext_2),
        .wen_ext_2   (wen_ext_2),
        .ren_ext_2   (ren_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .rdata_ext_2 (rdata_ext_2)
    );

    // Memories seen by the DUT: synchronous write, read data valid in the ren cycle.
    logic [31:0] imem_s [64];
    logic [31:0] dmem_s [64];
    logic        clr_mem = 1'b1;
    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 64; i++) begin
                imem_s[i] <= '0;
                dmem_s[i] <= '0;
            end
        end else begin
            if (wen_ext)   imem_s[addr_ext[5:0]]   <= wdata_ext;
            if (wen_ext_2) dmem_s[addr_ext_2[5:0]] <= wdata_ext_2;
        end
    end
    assign rdata_ext   = ren_ext   ? imem_s[addr_ext[5:0]]   : '0;
    assign rdata_ext_2 = ren_ext_2 ? dmem_s[addr_ext_2[5:0]] : '0;

    // Reference model: plain word arrays updated when a command is accepted.
    bit [31:0] ref_imem [64];
    bit [31:0] ref_dmem [64];

    typedef struct packed {
        logic        dm;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    acc_t        wr_q[$];
    acc_t        rd_q[$];
    logic [31:0] rsp_q[$];
    int          run_q[$];

    int   total = 0;
    int   bad = 0;
    logic hold_low = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        acc_t e;
        e.addr = a;
        e.data = d;
        e.dm   = op[0];
        case (op)
            3'b000: begin wr_q.push_back(e); ref_imem[a[5:0]] = d; end
            3'b001: begin wr_q.push_back(e); ref_dmem[a[5:0]] = d; end
            3'b010: begin e.data = '0; rd_q.push_back(e); rsp_q.push_back(ref_imem[a[5:0]]); end
            3'b011: begin e.data = '0; rd_q.push_back(e); rsp_q.push_back(ref_dmem[a[5:0]]); end
            3'b100: run_q.push_back(int'(d));
            default: ;
        endcase
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        int budget;
        @(negedge clk);
        host.cmd_valid = 1'b1;
        host.cmd_op    = op;
        host.cmd_addr  = a;
        host.cmd_data  = d;
        budget = 0;
        while (!host.cmd_ready && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        if (!host.cmd_ready) begin
            chk("cmd_accept_timeout", 64'd0, 64'd1);
            host.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model(op, a, d);
        #1 host.cmd_valid = 1'b0;
    endtask

    initial begin
        host.rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1 host.rsp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops expectations whenever the DUT shows an access, response or run end.
    int          en_len = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_data = '0;
    initial begin
        acc_t e;
        int   n;
        forever begin
            @(negedge clk);
            if (!arst_n) begin
                en_len = 0;
                pend   = 1'b0;
            end else begin
                chk("excl_enable", 64'(cpu_enable && (wen_ext || ren_ext || wen_ext_2 || ren_ext_2)), 64'd0);
                chk("wen_ren_imem", 64'(wen_ext && ren_ext), 64'd0);
                chk("wen_ren_dmem", 64'(wen_ext_2 && ren_ext_2), 64'd0);
                chk("ready_vs_busy", 64'(host.cmd_ready), 64'(!busy));
                if (!wen_ext && !ren_ext) chk("idle_imem_bus", {addr_ext, wdata_ext}, 64'd0);
                if (!wen_ext_2 && !ren_ext_2) chk("idle_dmem_bus", {addr_ext_2, wdata_ext_2}, 64'd0);
                if (wen_ext || wen_ext_2) begin
                    if (wr_q.size() == 0) chk("wr_unexpected", 64'd1, 64'd0);
                    else begin
                        e = wr_q.pop_front();
                        chk("wr_mem_sel", 64'(wen_ext_2), 64'(e.dm));
                        chk("wr_addr", e.dm ? addr_ext_2 : addr_ext, e.addr);
                        chk("wr_data", e.dm ? wdata_ext_2 : wdata_ext, e.data);
                    end
                end
                if (ren_ext || ren_ext_2) begin
                    if (rd_q.size() == 0) chk("rd_unexpected", 64'd1, 64'd0);
                    else begin
                        e = rd_q.pop_front();
                        chk("rd_mem_sel", 64'(ren_ext_2), 64'(e.dm));
                        chk("rd_addr", e.dm ? addr_ext_2 : addr_ext, e.addr);
                    end
                end
                if (pend) begin
                    chk("rsp_hold_valid", 64'(host.rsp_valid), 64'd1);
                    chk("rsp_hold_data", host.rsp_data, pend_data);
                end
                if (host.rsp_valid && host.rsp_ready) begin
                    if (rsp_q.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
                    else chk("rsp_data", host.rsp_data, rsp_q.pop_front());
                end
                pend      = host.rsp_valid && !host.rsp_ready;
                pend_data = host.rsp_data;
                if (cpu_enable) en_len++;
                if (run_done) begin
                    if (run_q.size() == 0) chk("run_unexpected", 64'd1, 64'd0);
                    else begin
                        n = run_q.pop_front();
                        chk("run_len", 64'(en_len), 64'(n));
                    end
                    chk("done_enable_low", 64'(cpu_enable), 64'd0);
                    en_len = 0;
                end
            end
        end
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, d;
        int          budget;
        host.cmd_valid = 1'b0;
        host.cmd_op    = '0;
        host.cmd_addr  = '0;
        host.cmd_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl_zero", {cpu_enable, busy, run_done, host.rsp_valid,
                              wen_ext, ren_ext, wen_ext_2, ren_ext_2}, 64'd0);
        chk("rst_bus_zero", {addr_ext | addr_ext_2, wdata_ext | wdata_ext_2}, 64'd0);
        chk("rst_rsp_data", host.rsp_data, 64'd0);
        arst_n  = 1'b1;
        clr_mem = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(host.cmd_ready), 64'd1);

        issue(OP_WR_IMEM, 32'h4, 32'h1234_5678);

        issue(OP_WR_DMEM, 32'h10, 32'hDEAD_BEEF);
        hold_low = 1'b1;
        issue(OP_RD_DMEM, 32'h10, 32'h0);
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("stall_rsp_valid", 64'(host.rsp_valid), 64'd1);
            chk("stall_rsp_data", host.rsp_data, 64'hDEAD_BEEF);
            chk("stall_cmd_ready", 64'(host.cmd_ready), 64'd0);
        end
        hold_low = 1'b0;

        issue(OP_RUN, 32'h0, 32'd7);
        repeat (7) begin
            @(negedge clk);
            chk("run7_enable", 64'(cpu_enable), 64'd1);
        end
        @(negedge clk);
        chk("run7_done", 64'(run_done), 64'd1);

        issue(OP_RUN, 32'h0, 32'd0);
        @(negedge clk);
        chk("run0_done", {cpu_enable, run_done}, 64'b01);
        @(negedge clk);
        chk("run0_single_pulse", {cpu_enable, run_done}, 64'b00);

        issue(OP_RUN, 32'h0, 32'd100);
        repeat (3) @(posedge clk);
        #2 chk("run100_enable", 64'(cpu_enable), 64'd1);
        arst_n = 1'b0;
        #1 chk("async_rst_enable", 64'(cpu_enable), 64'd0);
        run_q.delete();
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        chk("rst_run_ready", {host.cmd_ready, busy}, 64'b10);
        repeat (4) begin
            @(negedge clk);
            chk("rst_run_no_done", 64'(run_done), 64'd0);
        end

        issue(3'b101, 32'hFFFF_FFFF, 32'h5555_5555);
        issue(OP_WR_DMEM, 32'h20, 32'hCAFE_F00D);
        issue(OP_RD_DMEM, 32'h20, 32'h0);

        for (int k = 0; k < 60; k++) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
            d  = (op == OP_RUN) ? 32'($urandom_range(0, 12)) : 32'($urandom);
            issue(op, a, d);
        end

        budget = 0;
        while ((wr_q.size() + rd_q.size() + rsp_q.size() + run_q.size()) != 0 && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        @(negedge clk);
        chk("drain_wr", 64'(wr_q.size()), 64'd0);
        chk("drain_rd", 64'(rd_q.size()), 64'd0);
        chk("drain_rsp", 64'(rsp_q.size()), 64'd0);
        chk("drain_run", 64'(run_q.size()), 64'd0);
        chk("final_idle", {host.cmd_ready, busy}, 64'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
